data_loader: RTL and testbench

DATA_LOADER -- requirements
Module: data_loader

---
 rtl/data_loader_pkg.sv | 20 ++
 rtl/data_loader_if.sv | 27 ++
 rtl/frame_counter.sv | 37 +++
 rtl/data_loader.sv | 105 ++++++++++
 tb/tb_data_loader.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_loader_pkg.sv
// Shared constants and types for the PU input path: sample/frame geometry,
// MAC sizing and the data_loader state encodings.
package data_loader_pkg;

  function automatic int unsigned count_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int unsigned default_n                = 8;
  localparam int unsigned default_number_of_inputs = 62;
  localparam int unsigned count_w                  = count_width(default_number_of_inputs);

  // Product of two samples plus headroom for summing a full input vector.
  localparam int unsigned mac_prod_w = 2 * default_n;
  localparam int unsigned mac_acc_w  = mac_prod_w + count_w;

  typedef enum logic {StFill, StHold}  wr_state_e;
  typedef enum logic {StIdle, StValid} rd_state_e;

endpackage

// File: rtl/data_loader_if.sv
// Sample stream in, packed frame out. master = producer/consumer side,
// slave = the loader itself.
interface data_loader_if
  import data_loader_pkg::*;
#(
  parameter int unsigned n                = default_n,
  parameter int unsigned number_of_inputs = default_number_of_inputs
);
  logic [n-1:0]                  in_data;
  logic                          in_valid;
  logic                          in_last;
  logic                          in_ready;
  logic [number_of_inputs*n-1:0] data;
  logic                          data_valid;
  logic                          data_ready;
  logic                          frame_err;

  modport master (
    output in_data, in_valid, in_last, data_ready,
    input  in_ready, data, data_valid, frame_err
  );

  modport slave (
    input  in_data, in_valid, in_last, data_ready,
    output in_ready, data, data_valid, frame_err
  );
endinterface

// File: rtl/frame_counter.sv
// Sample index within a frame: increments per stored sample, wraps after the
// last slot, and clears on reset or a framing error.
module frame_counter #(
  parameter int unsigned max_count = 62,
  parameter int unsigned width     = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clear,
  output logic [width-1:0] count,
  output logic             at_last
);
  localparam logic [width-1:0] last_val = width'(max_count - 1);

  logic [width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc) begin
      count_d = (count_q == last_val) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign at_last = (count_q == last_val);
endmodule

// File: rtl/data_loader.sv
// Collects a frame of samples into a write bank and hands it to a read bank
// that drives the PU data input; double buffering keeps input at one sample/cycle.
module data_loader
  import data_loader_pkg::*;
#(
  parameter int unsigned n                = default_n,
  parameter int unsigned number_of_inputs = default_number_of_inputs
) (
  input logic          clk,
  input logic          rst,
  data_loader_if.slave bus
);
  localparam int unsigned cw = count_width(number_of_inputs);
  localparam int unsigned fw = number_of_inputs * n;

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;

  logic [fw-1:0] wr_bank_q, wr_bank_d;
  logic [fw-1:0] rd_bank_q, rd_bank_d;
  logic [cw-1:0] count;
  logic          at_last;
  logic          accept, complete, err, xfer;
  logic          frame_err_q;

  assign bus.in_ready = (wr_state_q == StFill);
  assign accept       = bus.in_valid && bus.in_ready;
  assign complete     = accept && at_last && bus.in_last;
  assign err          = accept && (at_last != bus.in_last);

  frame_counter #(
    .max_count(number_of_inputs),
    .width    (cw)
  ) u_frame_counter (
    .clk    (clk),
    .rst    (rst),
    .inc    (accept && !err),
    .clear  (err),
    .count  (count),
    .at_last(at_last)
  );

  // Stale slots after an error need no clearing: every slot is rewritten
  // before the next frame can complete.
  always_comb begin
    wr_bank_d = wr_bank_q;
    if (accept && !err) begin
      wr_bank_d[count*n +: n] = bus.in_data;
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    rd_state_d = rd_state_q;
    xfer       = 1'b0;

    case (wr_state_q)
      StFill: begin
        if (complete) begin
          if (rd_state_q == StIdle || bus.data_ready) begin
            xfer = 1'b1;
          end else begin
            wr_state_d = StHold;
          end
        end
      end
      StHold: begin
        if (bus.data_ready) begin
          xfer       = 1'b1;
          wr_state_d = StFill;
        end
      end
      default: wr_state_d = StFill;
    endcase

    if (xfer) begin
      rd_state_d = StValid;
    end else if (rd_state_q == StValid && bus.data_ready) begin
      rd_state_d = StIdle;
    end

    // The completing sample lands in the read bank on the same edge.
    rd_bank_d = xfer ? wr_bank_d : rd_bank_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q  <= StFill;
      rd_state_q  <= StIdle;
      wr_bank_q   <= '0;
      rd_bank_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      wr_state_q  <= wr_state_d;
      rd_state_q  <= rd_state_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      frame_err_q <= err;
    end
  end

  assign bus.data       = rd_bank_q;
  assign bus.data_valid = (rd_state_q == StValid);
  assign bus.frame_err  = frame_err_q;
endmodule

// File: tb/tb_data_loader.sv
// Bench for data_loader: control-vector table, directed frame sequences and a
// randomized stream checked against a frame scoreboard.
module tb_data_loader;
  import data_loader_pkg::*;

  localparam int unsigned n  = default_n;
  localparam int unsigned ni = default_number_of_inputs;
  localparam int unsigned fw = n * ni;

  typedef logic [fw-1:0] frame_t;

  typedef struct packed {
    logic       rst;
    logic       in_valid;
    logic       in_last;
    logic       data_ready;
    logic [2:0] exp;  // {in_ready, data_valid, frame_err} after the edge
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_loader_if #(.n(n), .number_of_inputs(ni)) bus ();

  data_loader #(.n(n), .number_of_inputs(ni)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int     checks = 0;
  int     passes = 0;
  int     fails = 0;
  int     delivered = 0;
  int     pushed = 0;
  int     err_pulses = 0;
  bit     done = 1'b0;
  frame_t exp_q[$];

  task automatic check(input string name, input frame_t got, input frame_t want);
    checks++;
    if (got === want) passes++;
    else begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got == want) passes++;
    else begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    fails++;
    $display("FAIL %s: got event/timeout want none", name);
  endtask

  // Scoreboard side: pop on every handshake, and watch held frames stay put.
  logic   prev_hold = 1'b0;
  frame_t prev_data;
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_hold) begin
        check_int("hold_valid", int'(bus.data_valid), 1);
        check("hold_data", bus.data, prev_data);
      end
      if (bus.frame_err) err_pulses++;
      if (bus.data_valid && bus.data_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_frame");
        else begin
          check("frame_data", bus.data, exp_q.pop_front());
          delivered++;
        end
      end
      prev_hold = bus.data_valid && !bus.data_ready;
      prev_data = bus.data;
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic idle(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  task automatic send_sample(input logic [n-1:0] d, input logic last, output bit ok,
                             output int waited);
    waited = 0;
    ok = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (bus.in_ready) break;
      waited++;
      if (waited > 2000) begin
        ok = 1'b0;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input frame_t f, input int count, input int last_at,
                            input bit gaps, output int stalls);
    bit ok;
    int w;
    stalls = 0;
    for (int k = 0; k < count; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      send_sample(f[k*n +: n], (k == last_at), ok, w);
      stalls += w;
      if (!ok) fail_now("accept_timeout");
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (count == ni && last_at == ni - 1) begin
      exp_q.push_back(f);
      pushed++;
    end
  endtask

  function automatic frame_t rand_frame();
    frame_t f;
    for (int k = 0; k < ni; k++) f[k*n +: n] = n'($urandom);
    return f;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t   vecs[9];
    frame_t fa, fb, f;
    int     st, d0, e0, t;

    vecs[0] = '{rst: 1, in_valid: 0, in_last: 0, data_ready: 0, exp: 3'b100};
    vecs[1] = '{rst: 0, in_valid: 0, in_last: 0, data_ready: 1, exp: 3'b100};
    vecs[2] = '{rst: 0, in_valid: 1, in_last: 1, data_ready: 0, exp: 3'b101};
    vecs[3] = '{rst: 0, in_valid: 0, in_last: 0, data_ready: 0, exp: 3'b100};
    vecs[4] = '{rst: 0, in_valid: 1, in_last: 0, data_ready: 0, exp: 3'b100};
    vecs[5] = '{rst: 1, in_valid: 1, in_last: 1, data_ready: 1, exp: 3'b100};
    vecs[6] = '{rst: 0, in_valid: 1, in_last: 0, data_ready: 0, exp: 3'b100};
    vecs[7] = '{rst: 0, in_valid: 1, in_last: 1, data_ready: 0, exp: 3'b101};
    vecs[8] = '{rst: 0, in_valid: 0, in_last: 0, data_ready: 0, exp: 3'b100};

    bus.in_data    = '0;
    bus.in_valid   = 1'b0;
    bus.in_last    = 1'b0;
    bus.data_ready = 1'b0;

    for (int i = 0; i < 9; i++) begin
      rst            = vecs[i].rst;
      bus.in_valid   = vecs[i].in_valid;
      bus.in_last    = vecs[i].in_last;
      bus.data_ready = vecs[i].data_ready;
      bus.in_data    = n'(i + 1);
      @(posedge clk);
      #1;
      check_int($sformatf("vec%0d", i), int'({bus.in_ready, bus.data_valid, bus.frame_err}),
                int'(vecs[i].exp));
      if (i == 0) check("reset_data", bus.data, '0);
    end
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;

    // Back-to-back frame 1..62 with the consumer always ready.
    bus.data_ready = 1'b1;
    for (int k = 0; k < ni; k++) f[k*n +: n] = n'(k + 1);
    send_frame(f, ni, ni - 1, 1'b0, st);
    check_int("t1_stalls", st, 0);
    check_int("t1_valid", int'(bus.data_valid), 1);
    check_int("t1_first", int'(bus.data[7:0]), 1);
    check_int("t1_last", int'(bus.data[495:488]), 62);
    idle(2);
    check_int("t1_delivered", delivered, 1);
    check_int("t1_valid_drop", int'(bus.data_valid), 0);

    // Two frames against a stalled consumer: second one parks in HOLD.
    bus.data_ready = 1'b0;
    for (int k = 0; k < ni; k++) fa[k*n +: n] = n'(k + 100);
    fb = rand_frame();
    d0 = delivered;
    send_frame(fa, ni, ni - 1, 1'b0, st);
    check_int("t2_a_valid", int'(bus.data_valid), 1);
    check("t2_a_data", bus.data, fa);
    send_frame(fb, ni, ni - 1, 1'b0, st);
    check_int("t2_b_stalls", st, 0);
    check_int("t2_hold_ready", int'(bus.in_ready), 0);
    check("t2_hold_data", bus.data, fa);
    idle(3);
    check_int("t2_hold_ready_late", int'(bus.in_ready), 0);
    check("t2_hold_data_late", bus.data, fa);
    bus.data_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.data_ready = 1'b0;
    check("t2_b_data", bus.data, fb);
    check_int("t2_b_valid", int'(bus.data_valid), 1);
    check_int("t2_refill_ready", int'(bus.in_ready), 1);
    bus.data_ready = 1'b1;
    idle(2);
    check_int("t2_delivered", delivered - d0, 2);

    // Early in_last at sample 10, then a clean frame.
    e0 = err_pulses;
    d0 = delivered;
    send_frame(rand_frame(), 10, 9, 1'b0, st);
    check_int("t3_err", int'(bus.frame_err), 1);
    check_int("t3_no_valid", int'(bus.data_valid), 0);
    idle(1);
    check_int("t3_err_pulse", int'(bus.frame_err), 0);
    send_frame(rand_frame(), ni, ni - 1, 1'b0, st);
    idle(2);
    check_int("t3_err_count", err_pulses - e0, 1);
    check_int("t3_delivered", delivered - d0, 1);

    // Full-length frame missing in_last.
    e0 = err_pulses;
    d0 = delivered;
    send_frame(rand_frame(), ni, -1, 1'b0, st);
    check_int("t4_err", int'(bus.frame_err), 1);
    check_int("t4_no_valid", int'(bus.data_valid), 0);
    idle(3);
    check_int("t4_no_valid_late", int'(bus.data_valid), 0);
    check_int("t4_err_count", err_pulses - e0, 1);
    check_int("t4_delivered", delivered - d0, 0);

    // Reset after 30 samples discards them.
    d0 = delivered;
    send_frame(rand_frame(), 30, -1, 1'b0, st);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_int("t5_ready", int'(bus.in_ready), 1);
    check_int("t5_valid", int'(bus.data_valid), 0);
    check("t5_data", bus.data, '0);
    idle(3);
    check_int("t5_valid_late", int'(bus.data_valid), 0);
    send_frame(rand_frame(), ni, ni - 1, 1'b0, st);
    idle(2);
    check_int("t5_delivered", delivered - d0, 1);

    // 100 frames with random producer gaps and consumer back-pressure.
    d0   = delivered;
    done = 1'b0;
    fork
      begin
        for (int fr = 0; fr < 100; fr++) send_frame(rand_frame(), ni, ni - 1, 1'b1, st);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          bus.data_ready = $urandom_range(0, 1) != 0;
        end
      end
    join
    bus.data_ready = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge clk);
      #1;
      t++;
    end
    idle(2);
    check_int("t6_drained", exp_q.size(), 0);
    check_int("t6_count", delivered - d0, 100);
    check_int("total_count", delivered, pushed);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
